// File: rtl/instr_fetch_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_responder_if
//  Description : Fetch-request / response bus plus program-load write port
//                between a datapath (master) and the instruction fetch
//                responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_responder_if;

  // Fetch request path (datapath -> responder)
  logic        fetchReq;
  logic [31:0] fetchAddr;

  // Fetch response path (responder -> datapath)
  logic        fetchReady;
  logic        instrValid;
  logic [31:0] instruction;
  logic        fetchErr;

  // Program-load write port (loader -> responder)
  logic        loadEnable;
  logic [31:0] loadAddr;
  logic [31:0] loadData;

  // Response statistics (responder -> observer)
  logic [15:0] respCount;

  // Datapath / loader side
  modport master (
    output fetchReq,
    output fetchAddr,
    output loadEnable,
    output loadAddr,
    output loadData,
    input  fetchReady,
    input  instrValid,
    input  instruction,
    input  fetchErr,
    input  respCount
  );

  // Responder side
  modport slave (
    input  fetchReq,
    input  fetchAddr,
    input  loadEnable,
    input  loadAddr,
    input  loadData,
    output fetchReady,
    output instrValid,
    output instruction,
    output fetchErr,
    output respCount
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_responder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_responder
//  Description : Instruction memory that answers single outstanding fetch
//                requests after a fixed LATENCY, flags misaligned or
//                out-of-range addresses, accepts program-load writes at any
//                time and counts issued responses (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_responder #(
  parameter int DEPTH   = 64,   // instruction words stored
  parameter int LATENCY = 2     // accept-to-response cycles, 1..7
) (
  input wire                     clock,
  input wire                     reset,
  instr_fetch_responder_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] c_DEPTH     = 32'(DEPTH);
  localparam logic [2:0]  c_WAIT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
  localparam bit          c_SINGLE    = (LATENCY == 1);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [31:0] r_addr;

  logic [31:0] r_mem [0:DEPTH-1];

  logic [31:0] r_instr;
  logic        r_err;
  logic [15:0] r_respCount;

  // --------------------------------------------------------------------------
  // Request / read-side decode
  // --------------------------------------------------------------------------
  logic            w_accept;
  logic            w_enter_resp;
  logic [31:0]     w_rd_addr;
  logic            w_rd_err;
  logic [c_AW-1:0] w_rd_idx;
  logic [31:0]     w_rd_data;

  assign w_accept     = (r_state == S_IDLE) && bus.fetchReq;
  assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

  // With LATENCY=1 the read happens on the accepting edge itself, so the
  // address comes straight from the bus; otherwise it is the latched one.
  assign w_rd_addr = (r_state == S_IDLE) ? bus.fetchAddr : r_addr;
  assign w_rd_err  = (w_rd_addr[1:0] != 2'b00) ||
                     ({2'b00, w_rd_addr[31:2]} >= c_DEPTH);
  assign w_rd_idx  = w_rd_addr[c_AW+1:2];
  assign w_rd_data = r_mem[w_rd_idx];

  // --------------------------------------------------------------------------
  // Load-side decode
  // --------------------------------------------------------------------------
  logic            w_ld_ok;
  logic [c_AW-1:0] w_ld_idx;

  assign w_ld_ok  = bus.loadEnable &&
                    (bus.loadAddr[1:0] == 2'b00) &&
                    ({2'b00, bus.loadAddr[31:2]} < c_DEPTH);
  assign w_ld_idx = bus.loadAddr[c_AW+1:2];

  // --------------------------------------------------------------------------
  // FSM next-state and wait-counter logic
  // --------------------------------------------------------------------------
  // Next state: IDLE accepts, WAIT counts down to 0, RESP lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.fetchReq) begin
          if (c_SINGLE) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State register, wait counter and request address latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_addr  <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr <= bus.fetchAddr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response registers
  // --------------------------------------------------------------------------
  // Capture data/error on the edge entering RESP; the error flag only lives
  // for that single cycle while the instruction word is held afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instr <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_enter_resp ? w_rd_err : 1'b0;
      if (w_enter_resp) begin
        r_instr <= w_rd_err ? 32'h0000_0000 : w_rd_data;
      end
    end
  end

  // Saturating count of responses issued, errors included.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_respCount <= 16'h0000;
    end else if (w_enter_resp && (r_respCount != 16'hFFFF)) begin
      r_respCount <= r_respCount + 16'h0001;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction memory
  // --------------------------------------------------------------------------
  // Program-load writes; not reset so a reset keeps the loaded program. A
  // read on the same edge sees the old word since both sides are registered.
  always_ff @(posedge clock) begin
    if (w_ld_ok) begin
      r_mem[w_ld_idx] <= bus.loadData;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.fetchReady  = (r_state == S_IDLE);
  assign bus.instrValid  = (r_state == S_RESP);
  assign bus.instruction = r_instr;
  assign bus.fetchErr    = r_err;
  assign bus.respCount   = r_respCount;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_responder
//  Description : Directed bench for instr_fetch_responder with one LATENCY=2
//                and one LATENCY=1 instance, a per-cycle reference model and
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  instr_fetch_responder_if if2 ();
  instr_fetch_responder_if if1 ();

  instr_fetch_responder #(.DEPTH(64), .LATENCY(2)) u_dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (if2)
  );

  instr_fetch_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: index 0 -> LATENCY=2 instance, index 1 -> LATENCY=1.
  // A request accepted at edge c responds on edge c+LAT-1 and the responder
  // is free to accept again at edge c+LAT+1.
  // --------------------------------------------------------------------------
  int          lat_of  [2] = '{2, 1};
  int          cyc         = 0;
  int          free_at [2] = '{0, 0};
  bit          pend    [2] = '{0, 0};
  int          due     [2];
  logic [31:0] paddr   [2];
  logic        ev      [2] = '{1'b0, 1'b0};
  logic        ee      [2] = '{1'b0, 1'b0};
  logic [31:0] ei      [2] = '{32'h0, 32'h0};
  logic [15:0] ec      [2] = '{16'h0, 16'h0};
  logic        er      [2] = '{1'b1, 1'b1};
  logic [31:0] mm      [2][64];

  logic        m_rq, m_le;
  logic [31:0] m_ra, m_la, m_ld;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        pend[k] = 1'b0; free_at[k] = 0;
        ev[k] = 1'b0; ee[k] = 1'b0; ei[k] = 32'h0; ec[k] = 16'h0; er[k] = 1'b1;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        m_rq = (k == 0) ? if2.fetchReq   : if1.fetchReq;
        m_ra = (k == 0) ? if2.fetchAddr  : if1.fetchAddr;
        m_le = (k == 0) ? if2.loadEnable : if1.loadEnable;
        m_la = (k == 0) ? if2.loadAddr   : if1.loadAddr;
        m_ld = (k == 0) ? if2.loadData   : if1.loadData;
        ev[k] = 1'b0;
        ee[k] = 1'b0;
        if (cyc >= free_at[k] && m_rq) begin
          pend[k]    = 1'b1;
          paddr[k]   = m_ra;
          due[k]     = cyc + lat_of[k] - 1;
          free_at[k] = cyc + lat_of[k] + 1;
        end
        if (pend[k] && due[k] == cyc) begin
          pend[k] = 1'b0;
          ev[k]   = 1'b1;
          if (paddr[k][1:0] != 2'b00 || (paddr[k] >> 2) >= 32'd64) begin
            ee[k] = 1'b1;
            ei[k] = 32'h0;
          end else begin
            ei[k] = mm[k][paddr[k][7:2]];
          end
          if (ec[k] != 16'hFFFF) ec[k] = ec[k] + 16'h1;
        end
        if (m_le && m_la[1:0] == 2'b00 && (m_la >> 2) < 32'd64) mm[k][m_la[7:2]] = m_ld;
        er[k] = (cyc + 1 >= free_at[k]);
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    chk("ready_L2", {31'b0, if2.fetchReady}, {31'b0, er[0]});
    chk("valid_L2", {31'b0, if2.instrValid}, {31'b0, ev[0]});
    chk("err_L2",   {31'b0, if2.fetchErr},   {31'b0, ee[0]});
    chk("instr_L2", if2.instruction, ei[0]);
    chk("count_L2", {16'b0, if2.respCount}, {16'b0, ec[0]});
    chk("ready_L1", {31'b0, if1.fetchReady}, {31'b0, er[1]});
    chk("valid_L1", {31'b0, if1.instrValid}, {31'b0, ev[1]});
    chk("err_L1",   {31'b0, if1.fetchErr},   {31'b0, ee[1]});
    chk("instr_L1", if1.instruction, ei[1]);
    chk("count_L1", {16'b0, if1.respCount}, {16'b0, ec[1]});
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all start and end at a falling edge)
  // --------------------------------------------------------------------------
  function automatic logic get_ready(input int k);
    return (k == 0) ? if2.fetchReady : if1.fetchReady;
  endfunction
  function automatic logic get_valid(input int k);
    return (k == 0) ? if2.instrValid : if1.instrValid;
  endfunction

  task automatic set_req(input int k, input logic r, input logic [31:0] a);
    if (k == 0) begin if2.fetchReq = r; if2.fetchAddr = a; end
    else        begin if1.fetchReq = r; if1.fetchAddr = a; end
  endtask

  task automatic load_both(input logic [31:0] a, input logic [31:0] d);
    if2.loadEnable = 1'b1; if2.loadAddr = a; if2.loadData = d;
    if1.loadEnable = 1'b1; if1.loadAddr = a; if1.loadData = d;
    @(negedge clock);
    if2.loadEnable = 1'b0;
    if1.loadEnable = 1'b0;
  endtask

  task automatic fetch(input int k, input logic [31:0] a,
                       output logic [31:0] ins, output logic e, output int lat);
    int n;
    set_req(k, 1'b1, a);
    n = 0;
    while (!get_ready(k) && n < 20) begin @(negedge clock); n++; end
    @(negedge clock);
    set_req(k, 1'b0, a);
    lat = 1;
    while (!get_valid(k) && lat < 20) begin @(negedge clock); lat++; end
    if (!get_valid(k)) begin
      total++; bad++;
      $display("FAIL fetch_timeout dut%0d: no instrValid within %0d cycles", k, lat);
    end
    ins = (k == 0) ? if2.instruction : if1.instruction;
    e   = (k == 0) ? if2.fetchErr    : if1.fetchErr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] ins;
    logic        e;
    int          lat, n, seen;
    int          tv [3];
    logic [31:0] got [3];

    if2.fetchReq = 1'b0; if2.fetchAddr = 32'h0;
    if2.loadEnable = 1'b0; if2.loadAddr = 32'h0; if2.loadData = 32'h0;
    if1.fetchReq = 1'b0; if1.fetchAddr = 32'h0;
    if1.loadEnable = 1'b0; if1.loadAddr = 32'h0; if1.loadData = 32'h0;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", {31'b0, if2.fetchReady}, 32'd1);
    chk("rst_valid", {31'b0, if2.instrValid}, 32'd0);
    chk("rst_instr", if2.instruction, 32'h0);
    chk("rst_count", {16'b0, if2.respCount}, 32'd0);

    load_both(32'h0, 32'h20080005);
    load_both(32'h4, 32'h21090003);
    load_both(32'h8, 32'h01095020);

    // First fetch: response two cycles after accept
    fetch(0, 32'h0, ins, e, lat);
    chk("f0_latency", lat, 32'd2);
    chk("f0_instr", ins, 32'h20080005);
    chk("f0_err", {31'b0, e}, 32'd0);
    chk("f0_count", {16'b0, if2.respCount}, 32'd1);

    // Held request stepping 0,4,8: responses every LATENCY+1 cycles
    set_req(0, 1'b1, 32'h0);
    seen = 0; n = 0;
    while (seen < 3 && n < 40) begin
      @(negedge clock);
      n++;
      if (if2.instrValid) begin
        tv[seen]  = n;
        got[seen] = if2.instruction;
        chk("b2b_ready_in_resp", {31'b0, if2.fetchReady}, 32'd0);
        seen++;
        if (seen < 3) if2.fetchAddr = 32'(seen * 4);
      end
    end
    set_req(0, 1'b0, 32'h0);
    chk("b2b_seen", seen, 32'd3);
    chk("b2b_w0", got[0], 32'h20080005);
    chk("b2b_w1", got[1], 32'h21090003);
    chk("b2b_w2", got[2], 32'h01095020);
    chk("b2b_gap01", tv[1] - tv[0], 32'd3);
    chk("b2b_gap12", tv[2] - tv[1], 32'd3);

    // Error responses and dropped loads
    fetch(0, 32'h2, ins, e, lat);
    chk("mis_err", {31'b0, e}, 32'd1);
    chk("mis_instr", ins, 32'h0);
    fetch(0, 32'h100, ins, e, lat);
    chk("oor_err", {31'b0, e}, 32'd1);
    chk("oor_instr", ins, 32'h0);
    load_both(32'h100, 32'hFFFFFFFF);
    load_both(32'h1, 32'hAAAAAAAA);
    fetch(0, 32'h0, ins, e, lat);
    chk("drop_w0", ins, 32'h20080005);
    chk("drop_err", {31'b0, e}, 32'd0);

    // Load on the RESP-entry edge: old value returned, new visible later
    repeat (2) @(negedge clock);
    set_req(0, 1'b1, 32'h4);
    @(negedge clock);
    set_req(0, 1'b0, 32'h4);
    if2.loadEnable = 1'b1; if2.loadAddr = 32'h4; if2.loadData = 32'hDEADBEEF;
    @(negedge clock);
    if2.loadEnable = 1'b0;
    chk("same_edge_valid", {31'b0, if2.instrValid}, 32'd1);
    chk("same_edge_old", if2.instruction, 32'h21090003);
    fetch(0, 32'h4, ins, e, lat);
    chk("later_new", ins, 32'hDEADBEEF);

    // Asynchronous reset during WAIT
    repeat (2) @(negedge clock);
    set_req(0, 1'b1, 32'h0);
    @(posedge clock);
    #1;
    chk("wait_ready", {31'b0, if2.fetchReady}, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'b0, if2.instrValid}, 32'd0);
    chk("arst_err", {31'b0, if2.fetchErr}, 32'd0);
    chk("arst_instr", if2.instruction, 32'h0);
    chk("arst_count", {16'b0, if2.respCount}, 32'd0);
    chk("arst_ready", {31'b0, if2.fetchReady}, 32'd1);
    @(negedge clock);
    set_req(0, 1'b0, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    fetch(0, 32'h0, ins, e, lat);
    chk("post_rst_w0", ins, 32'h20080005);
    chk("post_rst_count", {16'b0, if2.respCount}, 32'd1);

    // LATENCY=1 instance
    fetch(1, 32'h0, ins, e, lat);
    chk("l1_latency", lat, 32'd1);
    chk("l1_instr", ins, 32'h20080005);
    fetch(1, 32'h8, ins, e, lat);
    chk("l1_instr8", ins, 32'h01095020);
    chk("l1_count", {16'b0, if1.respCount}, 32'd2);

    // Saturation: preset the counter near the top instead of 65k fetches
    #1;
    force u_dut1.r_respCount = 16'hFFFD;
    ec[1] = 16'hFFFD;
    #1;
    release u_dut1.r_respCount;
    @(negedge clock);
    fetch(1, 32'h4, ins, e, lat);
    chk("sat_fffe", {16'b0, if1.respCount}, 32'h0000FFFE);
    fetch(1, 32'h0, ins, e, lat);
    chk("sat_ffff", {16'b0, if1.respCount}, 32'h0000FFFF);
    fetch(1, 32'h3, ins, e, lat);
    chk("sat_hold_err", {31'b0, e}, 32'd1);
    chk("sat_hold", {16'b0, if1.respCount}, 32'h0000FFFF);
    fetch(1, 32'h0, ins, e, lat);
    chk("sat_hold2", {16'b0, if1.respCount}, 32'h0000FFFF);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
